// File: rtl/decoder_pkg.sv
// Shared decode types for the CSR path: funct3 operation encoding,
// controller FSM states and small operation-classification helpers.
package decoder_pkg;

  // CSR instruction funct3 encoding
  typedef enum logic [2:0] {
    CSRRW  = 3'b001,
    CSRRS  = 3'b010,
    CSRRC  = 3'b011,
    CSRRWI = 3'b101,
    CSRRSI = 3'b110,
    CSRRCI = 3'b111
  } csr_t;

  // Access controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2,
    FAULT = 2'd3
  } csr_ctrl_state_t;

  // Slot operation that captures old without modifying the register
  localparam logic [2:0] CSR_OP_READ = 3'b000;

  // funct3 values 000 and 100 are not CSR instructions
  function automatic logic op_is_valid(input logic [2:0] op);
    return op[1:0] != 2'b00;
  endfunction

  // Set/clear family (CSRRS/CSRRC/CSRRSI/CSRRCI)
  function automatic logic op_is_set_clr(input logic [2:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/csr_access_ctrl_if.sv
// Request, slot-broadcast and writeback signals of the CSR access controller.
// master: the controller itself; slave: decoder / slots / register file side.
interface csr_access_ctrl_if #(
  parameter int NumCsr = 8
);
  logic                   req_valid;
  logic                   req_ready;
  logic [11:0]            req_addr;
  logic [2:0]             req_op;
  logic [4:0]             req_rs1;
  logic [4:0]             req_rd;
  logic [31:0]            req_in;

  logic [NumCsr-1:0]      csr_en;
  logic [2:0]             csr_op;
  logic [4:0]             csr_rs1;
  logic [4:0]             csr_rd;
  logic [31:0]            csr_in;
  logic [NumCsr-1:0][31:0] csr_old;

  logic                   wb_valid;
  logic                   wb_ready;
  logic [4:0]             wb_rd;
  logic [31:0]            wb_data;
  logic                   illegal;

  modport master (
    input  req_valid, req_addr, req_op, req_rs1, req_rd, req_in,
    output req_ready,
    output csr_en, csr_op, csr_rs1, csr_rd, csr_in,
    input  csr_old,
    output wb_valid, wb_rd, wb_data,
    input  wb_ready,
    output illegal
  );

  modport slave (
    output req_valid, req_addr, req_op, req_rs1, req_rd, req_in,
    input  req_ready,
    input  csr_en, csr_op, csr_rs1, csr_rd, csr_in,
    output csr_old,
    input  wb_valid, wb_rd, wb_data,
    output wb_ready,
    input  illegal
  );
endinterface

// File: rtl/csr_addr_decode.sv
// Combinational CSR address decode: one-hot slot select and hit flag.
// The offset uses 12-bit wrap-around, so addresses below AddrBase miss.
module csr_addr_decode #(
  parameter int          NumCsr   = 8,
  parameter logic [11:0] AddrBase = 12'h300
) (
  input  logic [11:0]       addr_i,
  output logic [NumCsr-1:0] sel_o,
  output logic              hit_o
);

  logic [11:0] offset;

  assign offset = addr_i - AddrBase;

  generate
    for (genvar gi = 0; gi < NumCsr; gi++) begin : g_sel
      assign sel_o[gi] = (offset == 12'(gi));
    end
  endgenerate

  assign hit_o = |sel_o;

endmodule

// File: rtl/csr_access_ctrl.sv
// CSR access controller: accepts one CSR instruction at a time, pulses the
// selected slot enable for one cycle, and returns the slot's old value as a
// register-file writeback. Illegal accesses produce a one-cycle pulse.
// Optional build macro CSR_RO_CHECK_EN: faults writes to addresses whose
// bits [11:10] are 2'b11 (read-only CSR space).
module csr_access_ctrl
  import decoder_pkg::*;
#(
  parameter int          NumCsr   = 8,
  parameter logic [11:0] AddrBase = 12'h300
) (
  input logic                clk,
  input logic                reset,
  csr_access_ctrl_if.master  bus
);

  csr_ctrl_state_t   state_q, state_d;
  logic [NumCsr-1:0] sel_q, sel_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rs1_q, rs1_d;
  logic [4:0]        rd_q, rd_d;
  logic [31:0]       in_q, in_d;

  logic [NumCsr-1:0] dec_sel;
  logic              dec_hit;
  logic              req_fire;
  logic              req_read_only;
  logic              ro_violation;
  logic              req_illegal;

  csr_addr_decode #(
    .NumCsr   (NumCsr),
    .AddrBase (AddrBase)
  ) u_decode (
    .addr_i (bus.req_addr),
    .sel_o  (dec_sel),
    .hit_o  (dec_hit)
  );

  // Set/clear with a zero source neither sets nor clears anything
  assign req_read_only = op_is_set_clr(bus.req_op) && (bus.req_rs1 == 5'd0);

`ifdef CSR_RO_CHECK_EN
  assign ro_violation = (bus.req_addr[11:10] == 2'b11) && !req_read_only;
`else
  assign ro_violation = 1'b0;
`endif

  assign req_illegal = !dec_hit || !op_is_valid(bus.req_op) || ro_violation;

  // Ready is held low while reset is asserted, even though state is IDLE
  assign bus.req_ready = (state_q == IDLE) && !reset;
  assign req_fire      = bus.req_valid && bus.req_ready;

  // Broadcasts always show the registered request
  assign bus.csr_op  = op_q;
  assign bus.csr_rs1 = rs1_q;
  assign bus.csr_rd  = rd_q;
  assign bus.csr_in  = in_q;
  assign bus.wb_rd   = rd_q;

  // State and captured-request registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      op_q    <= CSR_OP_READ;
      rs1_q   <= '0;
      rd_q    <= '0;
      in_q    <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      op_q    <= op_d;
      rs1_q   <= rs1_d;
      rd_q    <= rd_d;
      in_q    <= in_d;
    end
  end

  // Next-state, request capture and per-state outputs
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    op_d         = op_q;
    rs1_d        = rs1_q;
    rd_d         = rd_q;
    in_d         = in_q;
    bus.csr_en   = '0;
    bus.wb_valid = 1'b0;
    bus.wb_data  = '0;
    bus.illegal  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_fire) begin
          sel_d   = dec_sel;
          op_d    = req_read_only ? CSR_OP_READ : bus.req_op;
          rs1_d   = bus.req_rs1;
          rd_d    = bus.req_rd;
          in_d    = bus.req_in;
          state_d = req_illegal ? FAULT : ISSUE;
        end
      end
      ISSUE: begin
        bus.csr_en = sel_q;
        state_d    = (rd_q != 5'd0) ? RESP : IDLE;
      end
      RESP: begin
        // No slot is enabled here, so csr_old is stable
        bus.wb_valid = 1'b1;
        for (int i = 0; i < NumCsr; i++) begin
          if (sel_q[i]) bus.wb_data = bus.wb_data | bus.csr_old[i];
        end
        if (bus.wb_ready) state_d = IDLE;
      end
      FAULT: begin
        bus.illegal = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Directed bench for csr_access_ctrl with a behavioural model of 8 CSR slots.
module tb_csr_access_ctrl;
  import decoder_pkg::*;

  localparam int N = 8;

  logic clk = 1'b0;
  logic reset;
  logic slot_init;

  always #5 clk = ~clk;

  csr_access_ctrl_if #(.NumCsr(N)) bus ();

  csr_access_ctrl #(
    .NumCsr   (N),
    .AddrBase (12'h300)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  // Behavioural CSR slots: capture old and apply the operation on enable
  logic [31:0] slot_data [N];
  logic [31:0] slot_old  [N];

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (slot_init) begin
        slot_data[i] <= (i == 2) ? 32'h0000_1234 : 32'hC0DE_0000 + 32'(i);
        slot_old[i]  <= 32'h0;
      end else if (bus.csr_en[i]) begin
        slot_old[i] <= slot_data[i];
        case (bus.csr_op)
          3'b001:  slot_data[i] <= bus.csr_in;
          3'b010:  slot_data[i] <= slot_data[i] | bus.csr_in;
          3'b011:  slot_data[i] <= slot_data[i] & ~bus.csr_in;
          3'b101:  slot_data[i] <= {27'd0, bus.csr_rs1};
          3'b110:  slot_data[i] <= slot_data[i] | {27'd0, bus.csr_rs1};
          3'b111:  slot_data[i] <= slot_data[i] & ~{27'd0, bus.csr_rs1};
          default: slot_data[i] <= slot_data[i];
        endcase
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) bus.csr_old[i] = slot_old[i];
  end

  int passed = 0;
  int failed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Present a request, wait (bounded) for ready, return just after the handshake edge
  task automatic send(input logic [11:0] a, input logic [2:0] op, input logic [4:0] rs1,
                      input logic [4:0] rd, input logic [31:0] din);
    int waited = 0;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_op    = op;
    bus.req_rs1   = rs1;
    bus.req_rd    = rd;
    bus.req_in    = din;
    while (bus.req_ready !== 1'b1 && waited < 10) begin
      step;
      waited++;
    end
    chk("req_ready_wait", {31'd0, bus.req_ready}, 32'd1);
    $display("txn addr=%03h op=%03b rs1=%0d rd=%0d in=%08h", a, op, rs1, rd, din);
    step;
    bus.req_valid = 1'b0;
  endtask

  // Illegal access: one illegal pulse, no enable, no writeback, back to idle
  task automatic illegal_case(input string tag, input logic [11:0] a, input logic [2:0] op);
    send(a, op, 5'd1, 5'd8, 32'hFFFF_FFFF);
    chk({tag, "_illegal"}, {31'd0, bus.illegal}, 32'd1);
    chk({tag, "_en"}, {24'd0, bus.csr_en}, 32'd0);
    chk({tag, "_wbv"}, {31'd0, bus.wb_valid}, 32'd0);
    step;
    chk({tag, "_illegal_end"}, {31'd0, bus.illegal}, 32'd0);
    chk({tag, "_wbv_end"}, {31'd0, bus.wb_valid}, 32'd0);
    chk({tag, "_ready_end"}, {31'd0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    slot_init     = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = 12'h0;
    bus.req_op    = 3'b000;
    bus.req_rs1   = 5'd0;
    bus.req_rd    = 5'd0;
    bus.req_in    = 32'h0;
    bus.wb_ready  = 1'b1;
    step;
    step;

    // Reset values
    chk("rst_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("rst_en", {24'd0, bus.csr_en}, 32'd0);
    chk("rst_op", {29'd0, bus.csr_op}, 32'd0);
    chk("rst_rs1", {27'd0, bus.csr_rs1}, 32'd0);
    chk("rst_rd", {27'd0, bus.csr_rd}, 32'd0);
    chk("rst_in", bus.csr_in, 32'd0);
    chk("rst_wbv", {31'd0, bus.wb_valid}, 32'd0);
    chk("rst_wbrd", {27'd0, bus.wb_rd}, 32'd0);
    chk("rst_wbdata", bus.wb_data, 32'd0);
    chk("rst_illegal", {31'd0, bus.illegal}, 32'd0);
    reset     = 1'b0;
    slot_init = 1'b0;
    step;
    chk("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);

    // CSRRW to slot 2
    send(12'h302, 3'b001, 5'd0, 5'd5, 32'hDEAD_BEEF);
    chk("rw_en", {24'd0, bus.csr_en}, 32'h04);
    chk("rw_op", {29'd0, bus.csr_op}, 32'd1);
    chk("rw_in", bus.csr_in, 32'hDEAD_BEEF);
    chk("rw_rd", {27'd0, bus.csr_rd}, 32'd5);
    chk("rw_wbv_issue", {31'd0, bus.wb_valid}, 32'd0);
    chk("rw_ready_issue", {31'd0, bus.req_ready}, 32'd0);
    step;
    chk("rw_en_off", {24'd0, bus.csr_en}, 32'd0);
    chk("rw_wbv", {31'd0, bus.wb_valid}, 32'd1);
    chk("rw_wbrd", {27'd0, bus.wb_rd}, 32'd5);
    chk("rw_wbdata", bus.wb_data, 32'h0000_1234);
    step;
    chk("rw_wbv_done", {31'd0, bus.wb_valid}, 32'd0);
    chk("rw_ready_done", {31'd0, bus.req_ready}, 32'd1);

    // CSRRS rs1=0 to slot 0 is read-only even with a nonzero rs1 value
    send(12'h300, 3'b010, 5'd0, 5'd7, 32'hFFFF_FFFF);
    chk("rs0_op", {29'd0, bus.csr_op}, 32'd0);
    chk("rs0_en", {24'd0, bus.csr_en}, 32'h01);
    step;
    chk("rs0_wbdata", bus.wb_data, 32'hC0DE_0000);
    step;
    send(12'h300, 3'b010, 5'd0, 5'd7, 32'hFFFF_FFFF);
    step;
    chk("rs0_unchanged", bus.wb_data, 32'hC0DE_0000);
    step;
    send(12'h302, 3'b010, 5'd0, 5'd6, 32'h0);
    step;
    chk("rw_written", bus.wb_data, 32'hDEAD_BEEF);
    step;

    // CSRRW with rd=0: enable pulse, no writeback
    send(12'h301, 3'b001, 5'd0, 5'd0, 32'h0000_0055);
    chk("rd0_en", {24'd0, bus.csr_en}, 32'h02);
    step;
    chk("rd0_en_off", {24'd0, bus.csr_en}, 32'd0);
    chk("rd0_wbv", {31'd0, bus.wb_valid}, 32'd0);
    chk("rd0_ready", {31'd0, bus.req_ready}, 32'd1);

    // Illegal accesses
    illegal_case("miss_hi", 12'h308, 3'b001);
    illegal_case("miss_lo", 12'h2FF, 3'b001);
    illegal_case("bad_op", 12'h300, 3'b100);

    // Writeback backpressure for 4 cycles
    bus.wb_ready = 1'b0;
    send(12'h301, 3'b010, 5'd0, 5'd9, 32'h0);
    for (int k = 0; k < 4; k++) begin
      step;
      chk("bp_wbv", {31'd0, bus.wb_valid}, 32'd1);
      chk("bp_wbrd", {27'd0, bus.wb_rd}, 32'd9);
      chk("bp_wbdata", bus.wb_data, 32'h0000_0055);
      chk("bp_ready", {31'd0, bus.req_ready}, 32'd0);
    end
    step;
    bus.wb_ready = 1'b1;
    chk("bp_wbv_accept", {31'd0, bus.wb_valid}, 32'd1);
    step;
    chk("bp_wbv_done", {31'd0, bus.wb_valid}, 32'd0);
    chk("bp_ready_done", {31'd0, bus.req_ready}, 32'd1);

    // Reset during RESP drops the writeback
    bus.wb_ready = 1'b0;
    send(12'h300, 3'b001, 5'd0, 5'd3, 32'h0BAD_F00D);
    step;
    chk("rr_wbv_pre", {31'd0, bus.wb_valid}, 32'd1);
    reset = 1'b1;
    step;
    chk("rr_wbv", {31'd0, bus.wb_valid}, 32'd0);
    chk("rr_ready_in_rst", {31'd0, bus.req_ready}, 32'd0);
    reset        = 1'b0;
    bus.wb_ready = 1'b1;
    #1;
    chk("rr_ready", {31'd0, bus.req_ready}, 32'd1);

    // Subsequent requests are handled normally
    send(12'h303, 3'b101, 5'd17, 5'd4, 32'h0);
    chk("rwi_en", {24'd0, bus.csr_en}, 32'h08);
    chk("rwi_op", {29'd0, bus.csr_op}, 32'd5);
    chk("rwi_rs1", {27'd0, bus.csr_rs1}, 32'd17);
    step;
    chk("rwi_wbdata", bus.wb_data, 32'hC0DE_0003);
    step;
    send(12'h303, 3'b010, 5'd0, 5'd4, 32'h0);
    step;
    chk("rwi_written", bus.wb_data, 32'd17);
    step;
    send(12'h300, 3'b010, 5'd0, 5'd2, 32'h0);
    step;
    chk("rr_slot0", bus.wb_data, 32'h0BAD_F00D);
    step;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
